// File: rtl/sum_normalize_round52_if.sv
// Handshake and data bundle for the post-adder normalize/round stage.
// The slave side is the pipeline itself; the master side is whoever
// feeds sums in and consumes normalized results.
interface sum_normalize_round52_if #(
    parameter int EXP_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [52:0]      sum_in;
    logic [EXP_W-1:0] exp_in;
    logic             out_valid;
    logic             out_ready;
    logic [51:0]      mant_out;
    logic [EXP_W-1:0] exp_out;
    logic             zero_flag;
    logic             ovf_flag;
    logic             unf_flag;

    modport master (
        output in_valid, sum_in, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, zero_flag, ovf_flag, unf_flag
    );

    modport slave (
        input  in_valid, sum_in, exp_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, zero_flag, ovf_flag, unf_flag
    );
endinterface

// File: rtl/sum_normalize_round52.sv
// Normalize the 53-bit mantissa adder sum so the leading one lands on bit 51.
// A carry into bit 52 takes a 1-bit right shift with round-to-nearest-even
// (guard bit only, no sticky); otherwise the sum is left-shifted by its
// leading-zero count. Two-stage valid/ready pipeline, one result per cycle.
module sum_normalize_round52 #(
    parameter int EXP_W = 11
) (
    input logic                     clk,
    input logic                     rst,
    sum_normalize_round52_if.slave  bus
);
    // Exponent math is widened by two bits so both underflow (negative)
    // and the +2 of a round wrap near the top stay representable.
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_TWO  = EW'(2);
    localparam logic signed [EW-1:0] E_MAX  = $signed({2'b00, {EXP_W{1'b1}}});

    typedef struct packed {
        logic [51:0]      mant;
        logic [EXP_W-1:0] expo;
        logic             zf;
        logic             of;
        logic             uf;
    } res_t;

    // Leading zeros of the 52-bit no-carry field; 52 when the field is zero.
    function automatic logic [5:0] lzc52(input logic [51:0] v);
        logic [5:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int i = 51; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 6'd1;
            end
        end
        return n;
    endfunction

    // Right shift by one with RNE on the guard bit. Bit 52 of the result
    // set means the increment wrapped the 52-bit mantissa.
    function automatic logic [52:0] round_carry(input logic [52:0] s);
        return {1'b0, s[52:1]} + {52'd0, s[1] & s[0]};
    endfunction

    // Final priority: zero, then underflow flush, then overflow saturate.
    function automatic res_t saturate(input logic zero,
                                      input logic signed [EW-1:0] e,
                                      input logic [51:0] m);
        res_t r;
        r = '0;
        if (zero)            r.zf = 1'b1;
        else if (e <= E_ZERO) r.uf = 1'b1;
        else if (e >= E_MAX) begin
            r.of   = 1'b1;
            r.expo = '1;
        end else begin
            r.mant = m;
            r.expo = e[EXP_W-1:0];
        end
        return r;
    endfunction

    logic                    adv1, adv2;
    logic                    vld_p1;
    logic [52:0]             sum_p1;
    logic [EXP_W-1:0]        exp_p1;
    logic                    carry_p1;
    logic                    zero_p1;
    logic [5:0]              lzc_p1;
    logic [52:0]             rnd_p1;
    logic [51:0]             m_p1;
    logic signed [EW-1:0]    exp_ext_p1;
    logic signed [EW-1:0]    e_p1;
    res_t                    res_p1;

    assign adv2        = !bus.out_valid || bus.out_ready;
    assign adv1        = !vld_p1 || adv2;
    assign bus.in_ready = adv1;

    // ---- Stage 1: capture sum/exponent, classify, count leading zeros ----
    // Stage 1 occupancy; cleared on reset so in-flight data is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       vld_p1 <= 1'b0;
        else if (adv1) vld_p1 <= bus.in_valid;
    end

    // Stage 1 data, loaded only on an accepted input.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            sum_p1   <= bus.sum_in;
            exp_p1   <= bus.exp_in;
            carry_p1 <= bus.sum_in[52];
            zero_p1  <= (bus.sum_in == 53'd0);
            lzc_p1   <= lzc52(bus.sum_in[51:0]);
        end
    end

    // ---- Stage 2: shift, round, exponent adjust, saturate ----
    assign exp_ext_p1 = $signed({2'b00, exp_p1});

    // Select carry or left-normalize path and resolve flags.
    always_comb begin
        rnd_p1 = round_carry(sum_p1);
        if (carry_p1) begin
            m_p1 = rnd_p1[52] ? {1'b1, 51'd0} : rnd_p1[51:0];
            e_p1 = exp_ext_p1 + (rnd_p1[52] ? E_TWO : E_ONE);
        end else begin
            m_p1 = sum_p1[51:0] << lzc_p1;
            e_p1 = exp_ext_p1 - $signed({{(EW-6){1'b0}}, lzc_p1});
        end
        res_p1 = saturate(zero_p1, e_p1, m_p1);
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.mant_out  <= '0;
            bus.exp_out   <= '0;
            bus.zero_flag <= 1'b0;
            bus.ovf_flag  <= 1'b0;
            bus.unf_flag  <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.mant_out  <= res_p1.mant;
                bus.exp_out   <= res_p1.expo;
                bus.zero_flag <= res_p1.zf;
                bus.ovf_flag  <= res_p1.of;
                bus.unf_flag  <= res_p1.uf;
            end
        end
    end
endmodule

// File: tb/tb_sum_normalize_round52.sv
// Bench for sum_normalize_round52: directed literal cases, randomized
// streams under backpressure, and a mid-flight asynchronous reset.
module tb_sum_normalize_round52;
    localparam int EXP_W = 11;

    typedef struct packed {
        logic [51:0] mant;
        logic [10:0] expo;
        logic        zf;
        logic        of;
        logic        uf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sum_normalize_round52_if #(.EXP_W(EXP_W)) bus ();
    sum_normalize_round52 #(.EXP_W(EXP_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    res_t held;
    logic stalled = 1'b0;

    // Reference: plain integer arithmetic on the sum value.
    function automatic res_t model(logic [52:0] s, logic [10:0] ei);
        longint unsigned m;
        int              e;
        res_t            r;
        r = '0;
        if (s == 53'd0) begin
            r.zf = 1'b1;
            return r;
        end
        if (s[52]) begin
            m = 64'(s) >> 1;
            e = int'(ei) + 1;
            if (s[0] && m[0]) m = m + 1;
            if (m == (64'd1 << 52)) begin
                m = 64'd1 << 51;
                e = e + 1;
            end
        end else begin
            m = 64'(s);
            e = int'(ei);
            while (m < (64'd1 << 51)) begin
                m = m << 1;
                e = e - 1;
            end
        end
        if (e <= 0) r.uf = 1'b1;
        else if (e >= 2047) begin
            r.of   = 1'b1;
            r.expo = 11'h7FF;
        end else begin
            r.mant = m[51:0];
            r.expo = e[10:0];
        end
        return r;
    endfunction

    function automatic res_t mk(logic [51:0] m, logic [10:0] e, logic z, logic o, logic u);
        res_t r;
        r.mant = m; r.expo = e; r.zf = z; r.of = o; r.uf = u;
        return r;
    endfunction

    function automatic res_t dut_res();
        return {bus.mant_out, bus.exp_out, bus.zero_flag, bus.ovf_flag, bus.unf_flag};
    endfunction

    task automatic check(string nm, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Per-cycle monitor: ready rule, stall stability, in-order results.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            check("in_ready", 128'(bus.in_ready), 128'(!(exp_q.size() == 2 && !bus.out_ready)));
            if (stalled)
                check("stall_hold", {bus.out_valid, dut_res()}, {1'b1, held});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got output %h expected none", dut_res());
                end else begin
                    check("result", dut_res(), exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.sum_in, bus.exp_in));
            stalled = bus.out_valid && !bus.out_ready;
            held    = dut_res();
        end
    end

    // Single transaction on an idle pipe with out_ready high; checks latency
    // and the literal result, and pins the model to the same literal.
    task automatic directed(string nm, logic [52:0] s, logic [10:0] e, res_t req);
        check({"model_", nm}, model(s, e), req);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.sum_in = s; bus.exp_in = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({"early_", nm}, 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        check({"valid_", nm}, 128'(bus.out_valid), 128'(1));
        check({"lit_", nm}, dut_res(), req);
    endtask

    function automatic logic [52:0] rand_sum();
        logic [63:0] r;
        logic [52:0] s;
        r = {$urandom, $urandom};
        s = r[52:0];
        case ($urandom_range(0, 11))
            0:       s = '0;
            1, 2, 3: s[52] = 1'b1;
            4:       s = {1'b1, 50'h3FFFFFFFFFFFF, 2'($urandom_range(0, 3))};
            5:       s = {1'b1, 51'(r), 1'b1};
            default: s = s >> $urandom_range(1, 53);
        endcase
        return s;
    endfunction

    function automatic logic [10:0] rand_exp();
        case ($urandom_range(0, 3))
            0:       return 11'($urandom_range(0, 60));
            1:       return 11'($urandom_range(1990, 2047));
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    // Stream n inputs; mode 0 uses the 1,0,0,1 out_ready pattern with
    // back-to-back valid, mode 1 randomizes both sides.
    task automatic stream(int n, int mode);
        int   idx = 0;
        int   pc = 0;
        int   guard = 0;
        logic acc;
        @(posedge clk); #1;
        bus.sum_in = rand_sum(); bus.exp_in = rand_exp();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (idx < n && guard < 4000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++; pc++;
            bus.out_ready = (mode == 0) ? ((pc % 4 == 0) || (pc % 4 == 3))
                                        : ($urandom_range(0, 3) != 0);
            if (acc) begin
                idx++;
                bus.sum_in = rand_sum(); bus.exp_in = rand_exp();
                bus.in_valid = (idx < n) && (mode == 0 || $urandom_range(0, 3) != 0);
            end else if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 1) != 0);
            end
        end
        bus.in_valid = 1'b0;
        if (guard >= 4000) begin
            total++; bad++;
            $display("FAIL stream_timeout: accepted %0d required %0d", idx, n);
        end
    endtask

    task automatic drain();
        int g = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        @(negedge clk);
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        check("drain_idle", 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.sum_in = '0; bus.exp_in = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("reset_state", {bus.out_valid, dut_res()}, '0);
        check("reset_in_ready", 128'(bus.in_ready), 128'(1));
        #20;
        rst = 1'b0;

        directed("exact",   53'h8000000000000,  11'd1023, mk(52'h8000000000000, 11'd1023, 0, 0, 0));
        directed("tie",     53'h10000000000001, 11'd1023, mk(52'h8000000000000, 11'd1024, 0, 0, 0));
        directed("rup",     53'h10000000000003, 11'd1023, mk(52'h8000000000002, 11'd1024, 0, 0, 0));
        directed("wrap",    53'h1FFFFFFFFFFFFF, 11'd1023, mk(52'h8000000000000, 11'd1025, 0, 0, 0));
        directed("lnorm",   53'd1,              11'd1023, mk(52'h8000000000000, 11'd972,  0, 0, 0));
        directed("unf",     53'd1,              11'd40,   mk(52'h0,             11'd0,    0, 0, 1));
        directed("ovf",     53'h10000000000000, 11'd2046, mk(52'h0,             11'h7FF,  0, 1, 0));
        directed("zero",    53'd0,              11'd1023, mk(52'h0,             11'd0,    1, 0, 0));

        stream(10, 0);
        drain();
        stream(300, 1);
        drain();

        // Two transactions parked, then an asynchronous reset between edges.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.sum_in = 53'h8000000000000; bus.exp_in = 11'd500;
        @(posedge clk); #1;
        bus.sum_in = 53'h10000000000003; bus.exp_in = 11'd600;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("parked_valid", 128'(bus.out_valid), 128'(1));
        check("parked_in_ready", 128'(bus.in_ready), 128'(0));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_outs", {bus.out_valid, dut_res()}, '0);
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 128'(bus.out_valid), 128'(0));
        directed("after_rst", 53'h10000000000003, 11'd1023, mk(52'h8000000000002, 11'd1024, 0, 0, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
